// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timer core.
//   - FSM state encoding (IDLE/DELAY/TIMING/DONE/FOUL)
//   - BCD digit width and the terminal digit value
//   - LFSR seed, tap mask and one-step helper
package reaction_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DELAY  = 3'd1;
  localparam logic [2:0] ST_TIMING = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_FOUL   = 3'd4;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One decade of the BCD result counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear to 0 (priority over inc)
//   inc        : carry in, advance digit by one
//   digit      : current decimal digit, always 0..9
//   carry_out  : inc while digit is 9 (digit wraps to 0 this cycle)
module bcd_digit_counter
  import reaction_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  assign carry_out = inc && (digit == BCD_NINE);

  always_ff @(posedge clk) begin
    if (rst || clr)  digit <= '0;
    else if (inc)    digit <= (digit == BCD_NINE) ? '0 : digit + 1'b1;
  end

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-time measurement core: waits a pseudo-random go-delay, then
// counts elapsed milliseconds in packed BCD until the player reacts.
// Optional feature macro: BEST_TIME_EN (keeps the best valid time).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start_btn  : start level (debounced); rising edge starts a trial
//   react_btn  : react level (debounced); rising edge stops / fouls
//   led_go     : high while measuring
//   bcd_out    : result, digit i = [4i+3:4i], digit 0 = ms units
//   foul       : react before go; held until next start
//   overflow   : count saturated at all-9s
//   done       : 1-cycle pulse on entry to DONE or FOUL
//   best_bcd   : best valid time (0 when feature disabled or none yet)
module reaction_timer_core
  import reaction_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_DIV     = CLK_HZ / 1000,
  parameter int DIGITS       = 4,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 10
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_btn,
  input  logic                      react_btn,
  output logic                      led_go,
  output logic [BCD_W*DIGITS-1:0]   bcd_out,
  output logic                      foul,
  output logic                      overflow,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   best_bcd
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DLY_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS)) + 1;

  logic [2:0]       state, nxt_state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [15:0]      lfsr;
  logic [DLY_W-1:0] dly_cnt;
  logic             start_q, start_qq, react_q, react_qq;
  logic             start_rise, react_rise;
  logic             load_dly, dly_dec, clr_bcd, cnt_en, set_ovf, all9;
  logic [DIGITS:0]  carry;
  logic             unused_msd_carry;

  // Edge detect on registered levels: a press acts on the second clock.
  assign start_rise = start_q & ~start_qq;
  assign react_rise = react_q & ~react_qq;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= 1'b0;
      start_qq <= 1'b0;
      react_q  <= 1'b0;
      react_qq <= 1'b0;
    end else begin
      start_q  <= start_btn;
      start_qq <= start_q;
      react_q  <= react_btn;
      react_qq <= react_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end

  // Divider restarts on every state change so each state sees full ms.
  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || (nxt_state != state) || tick) div_cnt <= '0;
    else                                     div_cnt <= div_cnt + 1'b1;
  end

  always_comb begin
    all9 = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_out[BCD_W*i +: BCD_W] != BCD_NINE) all9 = 1'b0;
  end

  always_comb begin
    nxt_state = state;
    load_dly  = 1'b0;
    dly_dec   = 1'b0;
    clr_bcd   = 1'b0;
    cnt_en    = 1'b0;
    set_ovf   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FOUL: begin
        // start beats a simultaneous react here
        if (start_rise) begin
          nxt_state = ST_DELAY;
          load_dly  = 1'b1;
          clr_bcd   = 1'b1;
        end
      end
      ST_DELAY: begin
        // react beats the expiring delay
        if (react_rise) begin
          nxt_state = ST_FOUL;
          clr_bcd   = 1'b1;
        end else if (tick) begin
          if (dly_cnt <= DLY_W'(1)) nxt_state = ST_TIMING;
          else                      dly_dec   = 1'b1;
        end
      end
      ST_TIMING: begin
        // react beats a same-cycle tick: that tick is not counted
        if (react_rise) begin
          nxt_state = ST_DONE;
        end else if (tick) begin
          if (all9) begin
            nxt_state = ST_DONE;
            set_ovf   = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      dly_cnt  <= '0;
      foul     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= nxt_state;
      done  <= (nxt_state != state) &&
               ((nxt_state == ST_DONE) || (nxt_state == ST_FOUL));
      if (load_dly)
        dly_cnt <= DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[RAND_BITS-1:0]);
      else if (dly_dec)
        dly_cnt <= dly_cnt - 1'b1;
      if (load_dly)                                     foul <= 1'b0;
      else if (state == ST_DELAY && nxt_state == ST_FOUL) foul <= 1'b1;
      if (load_dly)     overflow <= 1'b0;
      else if (set_ovf) overflow <= 1'b1;
    end
  end

  assign led_go = (state == ST_TIMING);

  // Decade chain; carries ripple within the same cycle.
  assign carry[0] = cnt_en;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_counter u_dig (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_bcd),
      .inc       (carry[g]),
      .digit     (bcd_out[BCD_W*g +: BCD_W]),
      .carry_out (carry[g+1])
    );
  end

  // Saturation is caught by all9 before counting, so the top carry never fires.
  assign unused_msd_carry = carry[DIGITS];

`ifdef BEST_TIME_EN
  logic                    best_valid;
  logic [BCD_W*DIGITS-1:0] best_reg;

  // Packed BCD with legal digits orders the same as unsigned binary.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_valid <= 1'b0;
      best_reg   <= '0;
    end else if (state == ST_TIMING && react_rise &&
                 (!best_valid || bcd_out < best_reg)) begin
      best_valid <= 1'b1;
      best_reg   <= bcd_out;
    end
  end

  assign best_bcd = best_reg;
`else
  assign best_bcd = '0;
`endif

endmodule
